vpu_dst_port_controller: RTL

//  Write-side counterpart of the VPU source port controller. On start_i with a valid destination

---
 rtl/vpu_dst_port_controller.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/vpu_dst_port_controller.sv
// rtl/vpu_dst_port_controller.sv - VPU write-side port: pops one result word and issues one SRAM write per start.
// Optional request timeout is enabled by defining VPU_DST_PORT_TIMEOUT_EN.

package VPU_PKG;
  localparam int SRAM_BANK_CNT_LG2   = 2;
  localparam int SRAM_BANK_DEPTH_LG2 = 10;
  localparam int OPERAND_ADDR_WIDTH  = SRAM_BANK_CNT_LG2 + SRAM_BANK_DEPTH_LG2;
  localparam int SRAM_DATA_WIDTH     = 32;

  // Low address bits select the bank so consecutive operands interleave across banks.
  function automatic logic [SRAM_BANK_CNT_LG2-1:0] get_bank_id(input logic [OPERAND_ADDR_WIDTH-1:0] addr);
    return addr[SRAM_BANK_CNT_LG2-1:0];
  endfunction

  function automatic logic [SRAM_BANK_DEPTH_LG2-1:0] get_raddr(input logic [OPERAND_ADDR_WIDTH-1:0] addr);
    return addr[SRAM_BANK_CNT_LG2 +: SRAM_BANK_DEPTH_LG2];
  endfunction
endpackage

module vpu_dst_port_controller #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    wvalid_i,
  input  logic [VPU_PKG::OPERAND_ADDR_WIDTH-1:0]  waddr_i,
  input  logic                                    start_i,
  output logic                                    done_o,
  input  logic [VPU_PKG::SRAM_DATA_WIDTH-1:0]     result_fifo_rdata_i,
  input  logic                                    result_fifo_empty_i,
  output logic                                    result_fifo_rden_o,
  output logic                                    sram_req_o,
  input  logic                                    sram_ack_i,
  output logic [VPU_PKG::SRAM_BANK_CNT_LG2-1:0]   sram_wid_o,
  output logic [VPU_PKG::SRAM_BANK_DEPTH_LG2-1:0] sram_addr_o,
  output logic                                    sram_web_o,
  output logic                                    sram_wlast_o,
  output logic [VPU_PKG::SRAM_DATA_WIDTH-1:0]     sram_wdata_o,
  output logic                                    err_o
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_DATA = 2'd1,
    S_REQ       = 2'd2
  } state_e;

  state_e                                 state_q, state_d;
  logic                                   req_q, req_d;
  logic [VPU_PKG::SRAM_BANK_CNT_LG2-1:0]   wid_q, wid_d;
  logic [VPU_PKG::SRAM_BANK_DEPTH_LG2-1:0] addr_q, addr_d;
  logic                                   web_q, web_d;
  logic                                   wlast_q, wlast_d;
  logic [VPU_PKG::SRAM_DATA_WIDTH-1:0]     wdata_q, wdata_d;

`ifdef VPU_DST_PORT_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  always_comb begin
    state_d            = state_q;
    req_d              = req_q;
    wid_d              = wid_q;
    addr_d             = addr_q;
    web_d              = web_q;
    wlast_d            = wlast_q;
    wdata_d            = wdata_q;
    done_o             = 1'b0;
    result_fifo_rden_o = 1'b0;
`ifdef VPU_DST_PORT_TIMEOUT_EN
    cnt_d              = cnt_q;
    err_d              = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        done_o = 1'b1;
        if (start_i && wvalid_i) begin
          wid_d   = VPU_PKG::get_bank_id(waddr_i);
          addr_d  = VPU_PKG::get_raddr(waddr_i);
          state_d = S_WAIT_DATA;
        end
      end
      S_WAIT_DATA: begin
        if (!result_fifo_empty_i) begin
          result_fifo_rden_o = 1'b1;
          wdata_d            = result_fifo_rdata_i;
          req_d              = 1'b1;
          web_d              = 1'b0;
          wlast_d            = 1'b1;
          state_d            = S_REQ;
`ifdef VPU_DST_PORT_TIMEOUT_EN
          cnt_d              = '0;
`endif
        end
      end
      S_REQ: begin
        if (sram_ack_i) begin
          req_d   = 1'b0;
          web_d   = 1'b1;
          wlast_d = 1'b0;
          wid_d   = '0;
          addr_d  = '0;
          wdata_d = '0;
          state_d = S_IDLE;
        end
`ifdef VPU_DST_PORT_TIMEOUT_EN
        else begin
          // An ack on the limit cycle takes the branch above, so a late grant still completes cleanly.
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
            err_d   = 1'b1;
            req_d   = 1'b0;
            web_d   = 1'b1;
            wlast_d = 1'b0;
            wid_d   = '0;
            addr_d  = '0;
            wdata_d = '0;
            state_d = S_IDLE;
          end
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      wid_q   <= '0;
      addr_q  <= '0;
      web_q   <= 1'b1;
      wlast_q <= 1'b0;
      wdata_q <= '0;
`ifdef VPU_DST_PORT_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      wid_q   <= wid_d;
      addr_q  <= addr_d;
      web_q   <= web_d;
      wlast_q <= wlast_d;
      wdata_q <= wdata_d;
`ifdef VPU_DST_PORT_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign sram_req_o   = req_q;
  assign sram_wid_o   = wid_q;
  assign sram_addr_o  = addr_q;
  assign sram_web_o   = web_q;
  assign sram_wlast_o = wlast_q;
  assign sram_wdata_o = wdata_q;

`ifdef VPU_DST_PORT_TIMEOUT_EN
  assign err_o = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign err_o = 1'b0;
`endif

endmodule
